uart_rx: RTL and testbench

- Serial receiver that is the downstream peer of the UART transmitter. It consumes an 8N1 asynchronous line: 1 start bit (low), 8 data bits LSB first, and 1 stop bit (high).
- It oversamples with the system clock and samples each bit at mid-bit.
- It presents each received byte with a one-cycle valid strobe and flags framing errors.
- It sits between the board RX pin and the consuming logic, and closes the loopback path for the UART pair.

---
 rtl/uart_rx_if.sv | 25 ++
 rtl/uart_rx.sv | 170 +++++++++++++++++
 tb/tb_uart_rx.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// UART receive-side bundle: serial line in, received byte and status out.
// master = line driver / byte consumer side, slave = the receiver itself.
interface uart_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  modport master (
    output rx,
    input  data,
    input  rx_valid,
    input  frame_err,
    input  busy
  );

  modport slave (
    input  rx,
    output data,
    output rx_valid,
    output frame_err,
    output busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver. The serial line is double-flopped, a start edge is
// qualified at mid-start-bit, and each data/stop bit is sampled at mid-bit.
// A good frame updates data with a one-cycle rx_valid pulse; a low stop bit
// gives a one-cycle frame_err pulse and then waits for the line to go high.
module uart_rx #(
  parameter int BAUD_RATE   = 115_200,
  parameter int CLOCK_SPEED = 50_000_000
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.slave  bus
);

  localparam int BAUD_WIDTH = CLOCK_SPEED / BAUD_RATE;
  localparam int HALF_WIDTH = BAUD_WIDTH / 2;
  localparam int CNT_W      = $clog2(BAUD_WIDTH);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_WIDTH - 1);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  // Synchronizer
  logic             r_rx_meta;
  logic             r_rx_s;

  // Control state
  state_t           r_state;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_data;
  logic             r_rx_valid;
  logic             r_frame_err;

  // Assembly shift register (data path, not reset)
  logic [7:0]       r_shift;

  // Next-state values
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       w_idx_nxt;
  logic [7:0]       w_shift_nxt;
  logic [7:0]       w_data_nxt;
  logic             w_valid_nxt;
  logic             w_ferr_nxt;

  // Two-flop synchronizer; both flops reset high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= bus.rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // Next-state and strobe logic: counts to mid-bit, samples, then advances
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_clk_cnt;
    w_idx_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;

    case (r_state)
      IDLE: begin
        if (!r_rx_s) begin
          w_state_nxt = START;
          w_cnt_nxt   = '0;
        end
      end

      START: begin
        if (r_clk_cnt == HALF_LAST) begin
          w_cnt_nxt = '0;
          if (!r_rx_s) begin
            w_state_nxt = DATA;
            w_idx_nxt   = 3'd0;
          end else begin
            // Line went high again before mid-start: treat as a glitch
            w_state_nxt = IDLE;
          end
        end else begin
          w_cnt_nxt = r_clk_cnt + 1'b1;
        end
      end

      DATA: begin
        if (r_clk_cnt == BAUD_LAST) begin
          w_cnt_nxt              = '0;
          w_shift_nxt[r_bit_idx] = r_rx_s;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = STOP;
          end else begin
            w_idx_nxt = r_bit_idx + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_clk_cnt + 1'b1;
        end
      end

      STOP: begin
        if (r_clk_cnt == BAUD_LAST) begin
          w_cnt_nxt = '0;
          if (r_rx_s) begin
            w_data_nxt  = r_shift;
            w_valid_nxt = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            // Stop bit low: report once, then wait out a break / stuck-low line
            w_ferr_nxt  = 1'b1;
            w_state_nxt = WAIT_HIGH;
          end
        end else begin
          w_cnt_nxt = r_clk_cnt + 1'b1;
        end
      end

      WAIT_HIGH: begin
        if (r_rx_s) begin
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Control register bank; reset aborts any frame in flight without a strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_clk_cnt   <= '0;
      r_bit_idx   <= 3'd0;
      r_data      <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_clk_cnt   <= w_cnt_nxt;
      r_bit_idx   <= w_idx_nxt;
      r_data      <= w_data_nxt;
      r_rx_valid  <= w_valid_nxt;
      r_frame_err <= w_ferr_nxt;
    end
  end

  // Shift register holds bits of the frame being assembled; no reset needed
  always_ff @(posedge clk) begin
    r_shift <= w_shift_nxt;
  end

  assign bus.data      = r_data;
  assign bus.rx_valid  = r_rx_valid;
  assign bus.frame_err = r_frame_err;
  assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: drives 8N1 frames on the line, keeps a queue
// of the strobes each frame must produce, and checks strobes, latency and
// the held data output every cycle, plus literal spot checks.
module tb_uart_rx;

  localparam int BW      = 434;
  localparam int LAT_MIN = 4123;
  localparam int LAT_MAX = 4128;

  typedef struct {
    bit         is_err;
    logic [7:0] d;
    int         start;
  } evt_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  uart_rx_if bus ();

  uart_rx #(
    .BAUD_RATE   (115_200),
    .CLOCK_SPEED (50_000_000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         cyc    = 0;
  int         errors = 0;
  int         checks = 0;
  logic [7:0] m_data = 8'h00;
  evt_t       exp_q[$];
  evt_t       e_cur;
  int         lat;

  // Clock
  always #5 clk = ~clk;

  // Cycle counter: number of rising edges seen so far
  always @(posedge clk) cyc <= cyc + 1;

  // Compare process: strobes against the expected-event queue, data against the model
  always @(negedge clk) begin
    if (rst) begin
      m_data = 8'h00;
    end else begin
      if (exp_q.size() > 0 && !(bus.rx_valid || bus.frame_err) &&
          (cyc - exp_q[0].start) > LAT_MAX) begin
        checks++;
        errors++;
        $display("FAIL missing_strobe at cycle %0d: frame started %0d, actual none, required pulse within %0d..%0d",
                 cyc, exp_q[0].start, LAT_MIN, LAT_MAX);
        void'(exp_q.pop_front());
      end
      if (bus.rx_valid && bus.frame_err) begin
        checks++;
        errors++;
        $display("FAIL strobe_exclusive at cycle %0d: actual both high, required at most one", cyc);
      end
      if (bus.rx_valid || bus.frame_err) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe at cycle %0d: actual rx_valid=%0b frame_err=%0b, required none",
                   cyc, bus.rx_valid, bus.frame_err);
        end else begin
          e_cur = exp_q.pop_front();
          if (bus.frame_err !== e_cur.is_err) begin
            errors++;
            $display("FAIL strobe_kind at cycle %0d: actual frame_err=%0b, required frame_err=%0b",
                     cyc, bus.frame_err, e_cur.is_err);
          end
          lat = cyc - e_cur.start;
          checks++;
          if (lat < LAT_MIN || lat > LAT_MAX) begin
            errors++;
            $display("FAIL strobe_latency at cycle %0d: actual %0d, required %0d..%0d",
                     cyc, lat, LAT_MIN, LAT_MAX);
          end
          if (!e_cur.is_err) m_data = e_cur.d;
        end
      end
      checks++;
      if (bus.data !== m_data) begin
        errors++;
        $display("FAIL data_hold at cycle %0d: actual %02h, required %02h", cyc, bus.data, m_data);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual %0h, required %0h", nm, cyc, act, req);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; leaves the line at the stop level one full bit later
  task automatic send_frame(input logic [7:0] b, input logic stop_lvl, input int per, input bit track);
    evt_t e;
    bus.rx = 1'b0;
    if (track) begin
      e.is_err = ~stop_lvl;
      e.d      = b;
      e.start  = cyc;
      exp_q.push_back(e);
    end
    wait_clks(per);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      wait_clks(per);
    end
    bus.rx = stop_lvl;
    wait_clks(per);
  endtask

  initial begin
    bus.rx = 1'b1;
    rst    = 1'b1;
    wait_clks(5);
    rst = 1'b0;
    wait_clks(1);
    chk("reset_data", 32'(bus.data), 32'h00);
    chk("reset_valid", 32'(bus.rx_valid), 32'h0);
    chk("reset_ferr", 32'(bus.frame_err), 32'h0);
    chk("reset_busy", 32'(bus.busy), 32'h0);

    // Long idle line
    wait_clks(10000);
    chk("idle_busy", 32'(bus.busy), 32'h0);
    chk("idle_data", 32'(bus.data), 32'h00);

    // Single frame
    send_frame(8'hA5, 1'b1, BW, 1'b1);
    wait_clks(20);
    chk("frame_a5", 32'(bus.data), 32'hA5);

    // Back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1, BW, 1'b1);
    send_frame(8'hFF, 1'b1, BW, 1'b1);
    send_frame(8'h55, 1'b1, BW, 1'b1);
    wait_clks(20);
    chk("b2b_last", 32'(bus.data), 32'h55);

    // Line bit period 2% fast, then 2% slow
    send_frame(8'h5A, 1'b1, 425, 1'b1);
    send_frame(8'h96, 1'b1, 443, 1'b1);
    wait_clks(20);
    chk("tolerance_last", 32'(bus.data), 32'h96);

    // 100-clk glitch on an idle line
    bus.rx = 1'b0;
    wait_clks(50);
    chk("glitch_busy_rise", 32'(bus.busy), 32'h1);
    wait_clks(50);
    bus.rx = 1'b1;
    wait_clks(50);
    chk("glitch_busy_hold", 32'(bus.busy), 32'h1);
    wait_clks(150);
    chk("glitch_busy_drop", 32'(bus.busy), 32'h0);
    chk("glitch_data", 32'(bus.data), 32'h96);

    // Framing error followed by a stuck-low line
    send_frame(8'h3C, 1'b0, BW, 1'b1);
    wait_clks(2000);
    chk("ferr_busy_low_line", 32'(bus.busy), 32'h1);
    chk("ferr_data_kept", 32'(bus.data), 32'h96);
    bus.rx = 1'b1;
    wait_clks(5);
    chk("ferr_busy_release", 32'(bus.busy), 32'h0);
    send_frame(8'hC3, 1'b1, BW, 1'b1);
    wait_clks(20);
    chk("after_ferr_c3", 32'(bus.data), 32'hC3);

    // Reset in the middle of bit 4, released with the line high
    bus.rx = 1'b0;
    wait_clks(BW);
    for (int i = 0; i < 4; i++) begin
      bus.rx = 1'b0;
      wait_clks(BW);
    end
    wait_clks(217);
    rst    = 1'b1;
    bus.rx = 1'b1;
    wait_clks(4);
    rst = 1'b0;
    wait_clks(1);
    chk("abort_busy", 32'(bus.busy), 32'h0);
    chk("abort_data", 32'(bus.data), 32'h00);
    chk("abort_valid", 32'(bus.rx_valid), 32'h0);
    wait_clks(600);
    chk("abort_idle_busy", 32'(bus.busy), 32'h0);
    send_frame(8'h81, 1'b1, BW, 1'b1);
    wait_clks(20);
    chk("after_abort_81", 32'(bus.data), 32'h81);

    wait_clks(50);
    chk("pending_events", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
